peri_req_arbiter: RTL and testbench

Two-lane request arbiter and transaction sequencer that sits directly upstream of the peripheral bus decoder. It accepts peripheral load/store requests from both issue lanes of the two-issue core and grants one lane at a time, round-robin. It issues each request to the bus as a single-cycle strobe and waits for the peripheral's ready. It then returns the read data to the owning lane, or returns an error word if the peripheral never answers.

---
 rtl/peri_req_arbiter_if.sv | 49 ++++
 rtl/peri_req_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_peri_req_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peri_req_arbiter_if.sv
// Bundle of lane request/response and peripheral bus signals for peri_req_arbiter.
// slave  : the arbiter's view (takes lane requests, drives the bus).
// master : the environment's view (drives lane requests and bus responses).
interface peri_req_arbiter_if;
  logic        i_peri_rden_0;
  logic        i_peri_wren_0;
  logic [31:0] i_peri_addr_0;
  logic [31:0] i_peri_wdata_0;
  logic [3:0]  i_peri_wstrb_0;
  logic        i_peri_rden_1;
  logic        i_peri_wren_1;
  logic [31:0] i_peri_addr_1;
  logic [31:0] i_peri_wdata_1;
  logic [3:0]  i_peri_wstrb_1;
  logic        o_peri_gnt_0;
  logic        o_peri_gnt_1;
  logic        o_peri_ready_0;
  logic        o_peri_ready_1;
  logic [31:0] o_peri_rdata_0;
  logic [31:0] o_peri_rdata_1;
  logic        o_peri_rden;
  logic        o_peri_wren;
  logic [31:0] o_peri_addr;
  logic [31:0] o_peri_wdata;
  logic [3:0]  o_peri_wstrb;
  logic        i_peri_ready;
  logic [31:0] i_peri_rdata;
  logic        o_timeout_err;

  modport slave (
    input  i_peri_rden_0, i_peri_wren_0, i_peri_addr_0, i_peri_wdata_0, i_peri_wstrb_0,
    input  i_peri_rden_1, i_peri_wren_1, i_peri_addr_1, i_peri_wdata_1, i_peri_wstrb_1,
    input  i_peri_ready, i_peri_rdata,
    output o_peri_gnt_0, o_peri_gnt_1, o_peri_ready_0, o_peri_ready_1,
    output o_peri_rdata_0, o_peri_rdata_1,
    output o_peri_rden, o_peri_wren, o_peri_addr, o_peri_wdata, o_peri_wstrb,
    output o_timeout_err
  );

  modport master (
    output i_peri_rden_0, i_peri_wren_0, i_peri_addr_0, i_peri_wdata_0, i_peri_wstrb_0,
    output i_peri_rden_1, i_peri_wren_1, i_peri_addr_1, i_peri_wdata_1, i_peri_wstrb_1,
    output i_peri_ready, i_peri_rdata,
    input  o_peri_gnt_0, o_peri_gnt_1, o_peri_ready_0, o_peri_ready_1,
    input  o_peri_rdata_0, o_peri_rdata_1,
    input  o_peri_rden, o_peri_wren, o_peri_addr, o_peri_wdata, o_peri_wstrb,
    input  o_timeout_err
  );
endinterface

// File: rtl/peri_req_arbiter.sv
// Two-lane round-robin arbiter and single-outstanding transaction sequencer
// feeding the peripheral bus decoder. One request is granted in IDLE, issued as
// a one-cycle strobe, waited on (with timeout), and answered to its owner lane.
module peri_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input logic               i_clk,
  input logic               i_rst,
  peri_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rden_q, rden_d;
  logic               wren_q, wren_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               ready0_q, ready0_d;
  logic               ready1_q, ready1_d;
  logic [31:0]        rdata0_q, rdata0_d;
  logic [31:0]        rdata1_q, rdata1_d;
  logic               terr_q, terr_d;

  logic               req0_s, req1_s, win_s;
  logic               gnt0_s, gnt1_s;
  logic               done_s, done_err_s;
  logic [31:0]        done_data_s;

  // Round-robin winner: on a tie the lane that did not win last time goes next.
  always_comb begin
    req0_s = bus.i_peri_rden_0 | bus.i_peri_wren_0;
    req1_s = bus.i_peri_rden_1 | bus.i_peri_wren_1;
    if (req0_s && req1_s) begin
      win_s = ~rr_last_q;
    end else if (req1_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state, latching and response computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    rden_d      = 1'b0;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    terr_d      = 1'b0;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    done_s      = 1'b0;
    done_err_s  = 1'b0;
    done_data_s = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (req0_s || req1_s) begin
          gnt0_s    = ~win_s;
          gnt1_s    = win_s;
          owner_d   = win_s;
          rr_last_d = win_s;
          state_d   = ST_ISSUE;
          if (win_s) begin
            addr_d  = bus.i_peri_addr_1;
            wdata_d = bus.i_peri_wdata_1;
            wstrb_d = bus.i_peri_wstrb_1;
            wren_d  = bus.i_peri_wren_1;
            rden_d  = bus.i_peri_rden_1 & ~bus.i_peri_wren_1;
          end else begin
            addr_d  = bus.i_peri_addr_0;
            wdata_d = bus.i_peri_wdata_0;
            wstrb_d = bus.i_peri_wstrb_0;
            wren_d  = bus.i_peri_wren_0;
            rden_d  = bus.i_peri_rden_0 & ~bus.i_peri_wren_0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_peri_ready) begin
          done_s      = 1'b1;
          done_data_s = bus.i_peri_rdata;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        // A ready in the last WAIT cycle still beats the timeout.
        if (bus.i_peri_ready) begin
          done_s      = 1'b1;
          done_data_s = bus.i_peri_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_s      = 1'b1;
          done_err_s  = 1'b1;
          done_data_s = ERR_RDATA;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done_s) begin
      state_d = ST_RESP;
      terr_d  = done_err_s;
      if (owner_q) begin
        ready1_d = 1'b1;
        rdata1_d = done_data_s;
      end else begin
        ready0_d = 1'b1;
        rdata0_d = done_data_s;
      end
    end else begin
      terr_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ready0_q  <= ready0_d;
      ready1_q  <= ready1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      terr_q    <= terr_d;
    end
  end

  // Grants are combinational but forced low while reset is held.
  assign bus.o_peri_gnt_0   = gnt0_s & ~i_rst;
  assign bus.o_peri_gnt_1   = gnt1_s & ~i_rst;
  assign bus.o_peri_ready_0 = ready0_q;
  assign bus.o_peri_ready_1 = ready1_q;
  assign bus.o_peri_rdata_0 = rdata0_q;
  assign bus.o_peri_rdata_1 = rdata1_q;
  assign bus.o_peri_rden    = rden_q;
  assign bus.o_peri_wren    = wren_q;
  assign bus.o_peri_addr    = addr_q;
  assign bus.o_peri_wdata   = wdata_q;
  assign bus.o_peri_wstrb   = wstrb_q;
  assign bus.o_timeout_err  = terr_q;

endmodule

// File: tb/tb_peri_req_arbiter.sv
// Self-checking bench for peri_req_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_peri_req_arbiter;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [31:0] A0  = 32'h0001_0004;
  localparam logic [31:0] A1  = 32'h0002_0008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  peri_req_arbiter_if bus_if();

  peri_req_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8), .ERR_RDATA(ERR)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus_if)
  );

  typedef struct {
    logic        rst, rd0, wr0, rd1, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic        pr;
    logic [31:0] prd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        g0, g1, rden, wren, r0, r1;
    logic [31:0] d0, d1;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level model: a transaction is described by its grant cycle and
  // the cycle its response is due; all outputs follow from cycle arithmetic.
  logic        m_busy, m_owner, m_rd, m_wr, m_err, m_rr_last;
  int          m_tg, m_done;
  logic [31:0] m_addr, m_wdata, m_data;
  logic [3:0]  m_wstrb;
  logic [31:0] m_lane_rdata [2];
  logic [1:0]  e_gnt, e_rdy;
  logic        e_rden, e_wren, e_terr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.rst = 1'b0; s.rd0 = 1'b0; s.wr0 = 1'b0; s.rd1 = 1'b0; s.wr1 = 1'b0;
    s.addr0 = A0; s.addr1 = A1;
    s.wdata0 = 32'h1111_0000; s.wdata1 = 32'h2222_0000;
    s.wstrb0 = 4'hF; s.wstrb1 = 4'h3;
    s.pr = 1'b0; s.prd = 32'd0;
    return s;
  endfunction

  function automatic vec_t v(logic rd0, logic wr0, logic rd1, logic wr1, logic pr,
                             logic [31:0] prd, logic g0, logic g1, logic rden,
                             logic wren, logic r0, logic r1, logic [31:0] d0,
                             logic [31:0] d1);
    vec_t t;
    t.s = idle_s();
    t.s.rd0 = rd0; t.s.wr0 = wr0; t.s.rd1 = rd1; t.s.wr1 = wr1;
    t.s.pr = pr; t.s.prd = prd;
    t.g0 = g0; t.g1 = g1; t.rden = rden; t.wren = wren;
    t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1;
    return t;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_rr_last = 1'b1; m_owner = 1'b0;
    m_tg = -10; m_done = -1; m_err = 1'b0;
    m_lane_rdata[0] = 32'd0; m_lane_rdata[1] = 32'd0;
  endtask

  task automatic model_step(input stim_t s);
    logic fin, q0, q1, w;
    e_gnt = 2'b00; e_rdy = 2'b00; e_rden = 1'b0; e_wren = 1'b0; e_terr = 1'b0;
    fin = 1'b0;
    if (m_busy && cyc == m_done) begin
      e_rdy[m_owner] = 1'b1;
      m_lane_rdata[m_owner] = m_data;
      e_terr = m_err;
      fin = 1'b1;
    end
    if (m_busy && cyc == m_tg + 1) begin
      e_rden = m_rd;
      e_wren = m_wr;
    end
    if (!s.rst) begin
      q0 = s.rd0 | s.wr0;
      q1 = s.rd1 | s.wr1;
      if (!m_busy && (q0 || q1)) begin
        w = (q0 && q1) ? ~m_rr_last : q1;
        e_gnt[w] = 1'b1;
        m_rr_last = w; m_owner = w; m_busy = 1'b1;
        m_tg = cyc; m_done = -1; m_err = 1'b0;
        m_wr    = w ? s.wr1 : s.wr0;
        m_rd    = (w ? s.rd1 : s.rd0) & ~m_wr;
        m_addr  = w ? s.addr1 : s.addr0;
        m_wdata = w ? s.wdata1 : s.wdata0;
        m_wstrb = w ? s.wstrb1 : s.wstrb0;
      end else if (m_busy && m_done < 0 && cyc >= m_tg + 1) begin
        if (s.pr) begin
          m_done = cyc + 1; m_data = s.prd;
        end else if (cyc - (m_tg + 1) == TO) begin
          m_done = cyc + 1; m_data = ERR; m_err = 1'b1;
        end
      end
      if (fin) m_busy = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, advance model, compare everything.
  task automatic run_cycle(input stim_t s);
    @(negedge clk);
    rst = s.rst;
    bus_if.i_peri_rden_0 = s.rd0;   bus_if.i_peri_wren_0 = s.wr0;
    bus_if.i_peri_addr_0 = s.addr0; bus_if.i_peri_wdata_0 = s.wdata0;
    bus_if.i_peri_wstrb_0 = s.wstrb0;
    bus_if.i_peri_rden_1 = s.rd1;   bus_if.i_peri_wren_1 = s.wr1;
    bus_if.i_peri_addr_1 = s.addr1; bus_if.i_peri_wdata_1 = s.wdata1;
    bus_if.i_peri_wstrb_1 = s.wstrb1;
    bus_if.i_peri_ready = s.pr;     bus_if.i_peri_rdata = s.prd;
    #1;
    model_step(s);
    chk("gnt_0",   32'(bus_if.o_peri_gnt_0),   32'(e_gnt[0]));
    chk("gnt_1",   32'(bus_if.o_peri_gnt_1),   32'(e_gnt[1]));
    chk("rden",    32'(bus_if.o_peri_rden),    32'(e_rden));
    chk("wren",    32'(bus_if.o_peri_wren),    32'(e_wren));
    chk("ready_0", 32'(bus_if.o_peri_ready_0), 32'(e_rdy[0]));
    chk("ready_1", 32'(bus_if.o_peri_ready_1), 32'(e_rdy[1]));
    chk("rdata_0", bus_if.o_peri_rdata_0, m_lane_rdata[0]);
    chk("rdata_1", bus_if.o_peri_rdata_1, m_lane_rdata[1]);
    chk("timeout_err", 32'(bus_if.o_timeout_err), 32'(e_terr));
    if (e_rden || e_wren) begin
      chk("bus_addr",  bus_if.o_peri_addr,  m_addr);
      chk("bus_wdata", bus_if.o_peri_wdata, m_wdata);
      chk("bus_wstrb", 32'(bus_if.o_peri_wstrb), 32'(m_wstrb));
    end
    if (s.rst) model_reset();
    cyc++;
  endtask

  vec_t  tbl [14];
  stim_t s;
  logic        p_rd [2], p_wr [2], p_on [2];
  logic [31:0] p_addr [2], p_wdata [2];
  logic [3:0]  p_wstrb [2];

  initial begin
    // Directed table: simultaneous writes, single read, stray ready, rd+wr.
    tbl[0]  = v(0,1,0,1, 0,32'h0,  1,0,0,0, 0,0, 32'h0,  32'h0);
    tbl[1]  = v(0,0,0,1, 1,32'hC0, 0,0,0,1, 0,0, 32'h0,  32'h0);
    tbl[2]  = v(0,0,0,1, 0,32'h0,  0,0,0,0, 1,0, 32'hC0, 32'h0);
    tbl[3]  = v(0,0,0,1, 0,32'h0,  0,1,0,0, 0,0, 32'hC0, 32'h0);
    tbl[4]  = v(0,0,0,0, 1,32'hC1, 0,0,0,1, 0,0, 32'hC0, 32'h0);
    tbl[5]  = v(0,0,0,0, 0,32'h0,  0,0,0,0, 0,1, 32'hC0, 32'hC1);
    tbl[6]  = v(1,0,0,0, 0,32'h0,  1,0,0,0, 0,0, 32'hC0, 32'hC1);
    tbl[7]  = v(0,0,0,0, 1,32'h55, 0,0,1,0, 0,0, 32'hC0, 32'hC1);
    tbl[8]  = v(0,0,0,0, 0,32'h0,  0,0,0,0, 1,0, 32'h55, 32'hC1);
    tbl[9]  = v(0,0,0,0, 1,32'h77, 0,0,0,0, 0,0, 32'h55, 32'hC1);
    tbl[10] = v(0,0,0,0, 0,32'h0,  0,0,0,0, 0,0, 32'h55, 32'hC1);
    tbl[11] = v(1,1,0,0, 0,32'h0,  1,0,0,0, 0,0, 32'h55, 32'hC1);
    tbl[12] = v(0,0,0,0, 1,32'h99, 0,0,0,1, 0,0, 32'h55, 32'hC1);
    tbl[13] = v(0,0,0,0, 0,32'h0,  0,0,0,0, 1,0, 32'h99, 32'hC1);

    s = idle_s();
    bus_if.i_peri_rden_0 = 1'b0; bus_if.i_peri_wren_0 = 1'b0;
    bus_if.i_peri_rden_1 = 1'b0; bus_if.i_peri_wren_1 = 1'b0;
    bus_if.i_peri_ready = 1'b0;  bus_if.i_peri_rdata = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();

    // Reset state.
    run_cycle(s);
    chk("reset_addr",  bus_if.o_peri_addr, 32'd0);
    chk("reset_wdata", bus_if.o_peri_wdata, 32'd0);
    chk("reset_wstrb", 32'(bus_if.o_peri_wstrb), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i].s);
      chk($sformatf("tbl%0d_gnt0", i),  32'(bus_if.o_peri_gnt_0),   32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i),  32'(bus_if.o_peri_gnt_1),   32'(tbl[i].g1));
      chk($sformatf("tbl%0d_rden", i),  32'(bus_if.o_peri_rden),    32'(tbl[i].rden));
      chk($sformatf("tbl%0d_wren", i),  32'(bus_if.o_peri_wren),    32'(tbl[i].wren));
      chk($sformatf("tbl%0d_rdy0", i),  32'(bus_if.o_peri_ready_0), 32'(tbl[i].r0));
      chk($sformatf("tbl%0d_rdy1", i),  32'(bus_if.o_peri_ready_1), 32'(tbl[i].r1));
      chk($sformatf("tbl%0d_rdat0", i), bus_if.o_peri_rdata_0, tbl[i].d0);
      chk($sformatf("tbl%0d_rdat1", i), bus_if.o_peri_rdata_1, tbl[i].d1);
    end

    // Lane 1 read, ready in WAIT cycle 4: response at T+6, strobe only at T+1.
    for (int i = 0; i <= 6; i++) begin
      s = idle_s(); s.rd1 = (i == 0); s.pr = (i == 5); s.prd = 32'hA5A5_0001;
      run_cycle(s);
      chk("w4_rden",  32'(bus_if.o_peri_rden),    32'(i == 1));
      chk("w4_rdy1",  32'(bus_if.o_peri_ready_1), 32'(i == 6));
    end
    chk("w4_rdata1", bus_if.o_peri_rdata_1, 32'hA5A5_0001);

    // Lane 0 read, never answered: timeout at T+2+TO.
    for (int i = 0; i <= 2 + TO; i++) begin
      s = idle_s(); s.rd0 = (i == 0);
      run_cycle(s);
      chk("to_err",  32'(bus_if.o_timeout_err),  32'(i == 2 + TO));
      chk("to_rdy0", 32'(bus_if.o_peri_ready_0), 32'(i == 2 + TO));
    end
    chk("to_rdata0", bus_if.o_peri_rdata_0, ERR);

    // Lane 1 read, ready exactly in the last WAIT cycle: data wins, no error.
    for (int i = 0; i <= 2 + TO; i++) begin
      s = idle_s(); s.rd1 = (i == 0); s.pr = (i == 1 + TO); s.prd = 32'h1234_5678;
      run_cycle(s);
      chk("edge_err",  32'(bus_if.o_timeout_err),  32'd0);
      chk("edge_rdy1", 32'(bus_if.o_peri_ready_1), 32'(i == 2 + TO));
    end
    chk("edge_rdata1", bus_if.o_peri_rdata_1, 32'h1234_5678);

    // Reset during WAIT: everything clears, no late response, lane 0 wins tie.
    s = idle_s(); s.rd0 = 1'b1; run_cycle(s);
    s = idle_s(); run_cycle(s);
    s = idle_s(); s.rst = 1'b1; run_cycle(s);
    s = idle_s(); run_cycle(s);
    chk("rst_addr",   bus_if.o_peri_addr, 32'd0);
    chk("rst_wdata",  bus_if.o_peri_wdata, 32'd0);
    chk("rst_wstrb",  32'(bus_if.o_peri_wstrb), 32'd0);
    chk("rst_rdata0", bus_if.o_peri_rdata_0, 32'd0);
    chk("rst_rdata1", bus_if.o_peri_rdata_1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      s = idle_s(); s.pr = 1'b1; s.prd = 32'h0000_0BAD; run_cycle(s);
      chk("rst_no_rdy0", 32'(bus_if.o_peri_ready_0), 32'd0);
    end
    s = idle_s(); s.rd0 = 1'b1; s.rd1 = 1'b1; run_cycle(s);
    chk("tie_gnt0", 32'(bus_if.o_peri_gnt_0), 32'd1);
    chk("tie_gnt1", 32'(bus_if.o_peri_gnt_1), 32'd0);
    s = idle_s(); s.rd1 = 1'b1; s.pr = 1'b1; s.prd = 32'h0BAD_F00D; run_cycle(s);
    s = idle_s(); s.rd1 = 1'b1; run_cycle(s);
    chk("tie_rdy0",   32'(bus_if.o_peri_ready_0), 32'd1);
    chk("tie_rdata0", bus_if.o_peri_rdata_0, 32'h0BAD_F00D);
    s = idle_s(); s.rd1 = 1'b1; run_cycle(s);
    chk("tie_gnt1_next", 32'(bus_if.o_peri_gnt_1), 32'd1);
    s = idle_s(); s.pr = 1'b1; s.prd = 32'h0000_0111; run_cycle(s);
    s = idle_s(); run_cycle(s);

    // Randomized traffic against the model.
    for (int k = 0; k < 2; k++) p_on[k] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      s = idle_s();
      for (int k = 0; k < 2; k++) begin
        if (!p_on[k] && ($urandom % 4 == 0)) begin
          int op;
          op = $urandom_range(0, 2);
          p_on[k] = 1'b1;
          p_rd[k] = (op != 1);
          p_wr[k] = (op != 0);
          p_addr[k] = $urandom; p_wdata[k] = $urandom; p_wstrb[k] = 4'($urandom);
        end
      end
      s.rd0 = p_on[0] & p_rd[0]; s.wr0 = p_on[0] & p_wr[0];
      s.rd1 = p_on[1] & p_rd[1]; s.wr1 = p_on[1] & p_wr[1];
      s.addr0 = p_addr[0]; s.wdata0 = p_wdata[0]; s.wstrb0 = p_wstrb[0];
      s.addr1 = p_addr[1]; s.wdata1 = p_wdata[1]; s.wstrb1 = p_wstrb[1];
      s.pr  = ((c / 400) % 2 == 0) ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
      s.prd = $urandom;
      s.rst = ($urandom % 300 == 0);
      run_cycle(s);
      for (int k = 0; k < 2; k++) begin
        if (e_gnt[k] || s.rst) p_on[k] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
